// File: rtl/runway_allocator.sv
// Runway allocator: grants one of NUM_RUNWAYS runways per accepted request,
// keeps each granted runway busy for OCC_CYCLES cycles, and parks one emergency.
module runway_allocator #(
    parameter int NUM_RUNWAYS = 2,
    parameter int OCC_CYCLES  = 15,
    parameter int RUNWAY_W    = (NUM_RUNWAYS > 2) ? $clog2(NUM_RUNWAYS) : 1,
    parameter int CNT_W       = $clog2(OCC_CYCLES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [RUNWAY_W-1:0]    req_pref,
    input  logic                   req_emerg,
    output logic                   resp_valid,
    output logic                   resp_grant,
    output logic [RUNWAY_W-1:0]    resp_runway,
    output logic [NUM_RUNWAYS-1:0] busy,
    output logic                   emerg_pending
);

    localparam int PREF_SPAN = 1 << RUNWAY_W;

    typedef enum logic {
        ST_OPEN,
        ST_HOLD
    } state_e;

    state_e state_q, state_d;

    logic [NUM_RUNWAYS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [RUNWAY_W-1:0]               epref_q, epref_d;
    logic                              resp_valid_q, resp_valid_d;
    logic                              resp_grant_q, resp_grant_d;
    logic [RUNWAY_W-1:0]               resp_runway_q, resp_runway_d;

    logic [NUM_RUNWAYS-1:0] busy_w, free_w;
    logic [PREF_SPAN-1:0]   free_ext;
    logic [RUNWAY_W-1:0]    pref_w, sel_w;
    logic                   found_w;
    logic                   any_free, accept, hold_grant, do_grant, do_deny, do_park;

    // Out-of-range preferences index zero-padding in free_ext, so they fall back naturally.
    always_comb begin
        busy_w = '0;
        for (int unsigned i = 0; i < NUM_RUNWAYS; i++) begin
            busy_w[i] = (cnt_q[i] != '0);
        end
        free_w   = ~busy_w;
        any_free = |free_w;
        free_ext = '0;
        free_ext[NUM_RUNWAYS-1:0] = free_w;
        pref_w   = (state_q == ST_HOLD) ? epref_q : req_pref;

        sel_w   = '0;
        found_w = 1'b0;
        for (int unsigned i = 0; i < NUM_RUNWAYS; i++) begin
            if (free_w[i] && !found_w) begin
                sel_w   = RUNWAY_W'(i);
                found_w = 1'b1;
            end
        end
        if (free_ext[pref_w]) begin
            sel_w = pref_w;
        end
    end

    always_comb begin
        accept     = req_valid && (state_q == ST_OPEN);
        hold_grant = (state_q == ST_HOLD) && any_free;
        do_grant   = hold_grant || (accept && any_free);
        do_deny    = accept && !any_free && !req_emerg;
        do_park    = accept && !any_free && req_emerg;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OPEN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OPEN: if (do_park) state_d = ST_HOLD;
            ST_HOLD: if (any_free) state_d = ST_OPEN;
            default: state_d = ST_OPEN;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready     = (state_q == ST_OPEN);
        emerg_pending = (state_q == ST_HOLD);
        busy          = busy_w;
        resp_valid    = resp_valid_q;
        resp_grant    = resp_grant_q;
        resp_runway   = resp_runway_q;
    end

    always_comb begin
        cnt_d = cnt_q;
        for (int unsigned i = 0; i < NUM_RUNWAYS; i++) begin
            if (busy_w[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
            if (do_grant && (sel_w == RUNWAY_W'(i))) begin
                cnt_d[i] = CNT_W'(OCC_CYCLES);
            end
        end

        epref_d       = do_park ? req_pref : epref_q;
        resp_valid_d  = do_grant || do_deny;
        resp_grant_d  = resp_grant_q;
        resp_runway_d = resp_runway_q;
        if (do_grant) begin
            resp_grant_d  = 1'b1;
            resp_runway_d = sel_w;
        end else if (do_deny) begin
            resp_grant_d  = 1'b0;
            resp_runway_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            epref_q       <= '0;
            resp_valid_q  <= 1'b0;
            resp_grant_q  <= 1'b0;
            resp_runway_q <= '0;
        end else begin
            cnt_q         <= cnt_d;
            epref_q       <= epref_d;
            resp_valid_q  <= resp_valid_d;
            resp_grant_q  <= resp_grant_d;
            resp_runway_q <= resp_runway_d;
        end
    end

endmodule

// File: tb/tb_runway_allocator.sv
// Randomised bench for runway_allocator: two configurations (2x15, 5x1) checked
// against a release-time model of runway occupancy.
module tb_runway_allocator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       a_valid, a_ready, a_emerg, a_rv, a_rg, a_pend;
    logic [0:0] a_pref, a_rr;
    logic [1:0] a_busy;

    logic       b_valid, b_ready, b_emerg, b_rv, b_rg, b_pend;
    logic [2:0] b_pref, b_rr;
    logic [4:0] b_busy;

    runway_allocator #(.NUM_RUNWAYS(2), .OCC_CYCLES(15)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_valid), .req_ready(a_ready), .req_pref(a_pref), .req_emerg(a_emerg),
        .resp_valid(a_rv), .resp_grant(a_rg), .resp_runway(a_rr),
        .busy(a_busy), .emerg_pending(a_pend)
    );

    runway_allocator #(.NUM_RUNWAYS(5), .OCC_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_valid), .req_ready(b_ready), .req_pref(b_pref), .req_emerg(b_emerg),
        .resp_valid(b_rv), .resp_grant(b_rg), .resp_runway(b_rr),
        .busy(b_busy), .emerg_pending(b_pend)
    );

    logic [31:0] o_busy [2];
    logic [31:0] o_rr   [2];
    logic        o_rv   [2];
    logic        o_rg   [2];
    logic        o_rdy  [2];
    logic        o_pend [2];

    assign o_busy[0] = 32'(a_busy);
    assign o_busy[1] = 32'(b_busy);
    assign o_rr[0]   = 32'(a_rr);
    assign o_rr[1]   = 32'(b_rr);
    assign o_rv[0]   = a_rv;
    assign o_rv[1]   = b_rv;
    assign o_rg[0]   = a_rg;
    assign o_rg[1]   = b_rg;
    assign o_rdy[0]  = a_ready;
    assign o_rdy[1]  = b_ready;
    assign o_pend[0] = a_pend;
    assign o_pend[1] = b_pend;

    // Model: each runway is busy until an absolute edge number; free at edge e iff until < e.
    int nr  [2] = '{2, 5};
    int occ [2] = '{15, 1};
    int until_e [2][16];
    bit m_pend  [2];
    int m_ppref [2];
    bit m_rv    [2];
    bit m_rg    [2];
    int m_rr    [2];
    int edge_n;

    int n_checks;
    int n_pass;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s @edge %0d: got %0d, expected %0d", tag, edge_n, obs, expv);
        end
    endtask

    task automatic model_edge(input int k, input bit r, input bit v, input int pref, input bit em);
        int e;
        int p;
        int sel;
        e = edge_n;
        if (r) begin
            for (int i = 0; i < 16; i++) until_e[k][i] = 0;
            m_pend[k] = 0;
            m_rv[k]   = 0;
            m_rg[k]   = 0;
            m_rr[k]   = 0;
            return;
        end
        p   = m_pend[k] ? m_ppref[k] : pref;
        sel = -1;
        if (p < nr[k] && until_e[k][p] < e) begin
            sel = p;
        end else begin
            for (int i = 0; i < nr[k]; i++) begin
                if (sel < 0 && until_e[k][i] < e) sel = i;
            end
        end
        m_rv[k] = 0;
        if (m_pend[k] || v) begin
            if (sel >= 0) begin
                until_e[k][sel] = e + occ[k];
                m_rv[k]   = 1;
                m_rg[k]   = 1;
                m_rr[k]   = sel;
                m_pend[k] = 0;
            end else if (!m_pend[k]) begin
                if (em) begin
                    m_pend[k]  = 1;
                    m_ppref[k] = pref;
                end else begin
                    m_rv[k] = 1;
                    m_rg[k] = 0;
                    m_rr[k] = 0;
                end
            end
        end
    endtask

    task automatic check_inst(input int k);
        logic [31:0] eb;
        eb = '0;
        for (int i = 0; i < nr[k]; i++) eb[i] = (edge_n < until_e[k][i]);
        check_eq($sformatf("k%0d busy", k), o_busy[k], eb);
        check_eq($sformatf("k%0d resp_valid", k), 32'(o_rv[k]), 32'(m_rv[k]));
        check_eq($sformatf("k%0d resp_grant", k), 32'(o_rg[k]), 32'(m_rg[k]));
        check_eq($sformatf("k%0d resp_runway", k), o_rr[k], m_rr[k]);
        check_eq($sformatf("k%0d emerg_pending", k), 32'(o_pend[k]), 32'(m_pend[k]));
        check_eq($sformatf("k%0d req_ready", k), 32'(o_rdy[k]), 32'(!m_pend[k]));
    endtask

    task automatic step(input bit r, input bit av, input int ap, input bit ae,
                        input bit bv, input int bp, input bit be);
        rst     = r;
        a_valid = av;
        a_pref  = ap[0:0];
        a_emerg = ae;
        b_valid = bv;
        b_pref  = bp[2:0];
        b_emerg = be;
        edge_n++;
        model_edge(0, r, av, ap, ae);
        model_edge(1, r, bv, bp, be);
        @(posedge clk);
        #1;
        check_inst(0);
        check_inst(1);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        edge_n   = 0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) until_e[k][i] = 0;
            m_pend[k] = 0; m_ppref[k] = 0; m_rv[k] = 0; m_rg[k] = 0; m_rr[k] = 0;
        end

        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);

        // Single grant on preferred runway 1, then let it release.
        step(0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 0, 0);

        // Fallback, deny, then park an emergency while a normal request is held.
        step(0, 1, 0, 0, 1, 3, 0);
        step(0, 1, 0, 0, 1, 3, 0);
        step(0, 1, 0, 0, 1, 3, 0);
        step(0, 1, 1, 1, 1, 3, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 1, 0, 1, 7, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 0);

        // Reset while both busy and an emergency is parked.
        step(0, 1, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 1, 6, 0);
        step(0, 1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99) == 0,
                 $urandom_range(99) < 60, int'($urandom_range(1)), $urandom_range(3) == 0,
                 $urandom_range(99) < 70, int'($urandom_range(7)), $urandom_range(3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
